// File: rtl/clk_div_gen.sv
`default_nettype none
// ============================================================================
//  Module   : clk_div_gen
//  Purpose  : Multi-channel programmable clock divider. Each channel counts
//             0..dsh and wraps, producing a one-cycle CE pulse per wrap and a
//             registered divided clock (high for floor(N/2) of N counts).
//             A channel may be cascaded so it only advances when the channel
//             below it wraps on the same edge.
//  Ports    : CLK_24M  - sole clock, rising edge
//             nRESET   - asynchronous active-low reset
//             EN       - global count enable
//             SYNC     - realign pulse, reloads every channel
//             DIV      - per-channel ratio minus one, NCH*CW bits
//             PHASE    - per-channel counter load value on SYNC/prime
//             MODE     - per-channel cascade select (bit 0 has no effect)
//             CE       - registered one-cycle pulse per channel wrap
//             CLK_OUT  - registered divided clock per channel
//             TC       - combinational terminal count of channel 0
//  Revision : 1.0 - initial release
// ============================================================================
module clk_div_gen #(
    parameter int NCH = 4,
    parameter int CW  = 4
) (
    input  logic              CLK_24M,
    input  logic              nRESET,
    input  logic              EN,
    input  logic              SYNC,
    input  logic [NCH*CW-1:0] DIV,
    input  logic [NCH*CW-1:0] PHASE,
    input  logic [NCH-1:0]    MODE,
    output logic [NCH-1:0]    CE,
    output logic [NCH-1:0]    CLK_OUT,
    output logic              TC
);

    localparam logic [CW-1:0] ONE_CW = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW:0]   ONE_W  = {{CW{1'b0}}, 1'b1};

    logic           prime;
    logic           load;
    logic [NCH-1:0] up;      // wrap of the channel below (1 for channel 0)
    logic [NCH-1:0] adv;
    logic [NCH-1:0] at_top;  // cnt_i == dsh_i
    logic [NCH-1:0] wrap;

    // The first enabled edge after reset behaves exactly like SYNC.
    assign load = EN & (SYNC | ~prime);

    always_ff @(posedge CLK_24M or negedge nRESET) begin
        if (!nRESET) begin
            prime <= 1'b0;
        end else if (EN) begin
            prime <= 1'b1;
        end
    end

    assign TC = EN & prime & at_top[0] & ~SYNC;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [CW-1:0] cnt;
        logic [CW-1:0] dsh;
        logic [CW-1:0] cnt_nxt;
        logic [CW-1:0] dsh_nxt;
        logic [CW-1:0] div_i;
        logic [CW-1:0] ph_i;
        logic [CW:0]   half;
        logic          written;
        logic          ce_q;
        logic          ce_nxt;
        logic          co_q;
        logic          co_nxt;

        assign div_i = DIV[i*CW +: CW];
        assign ph_i  = PHASE[i*CW +: CW];

        if (i == 0) begin : g_root
            assign up[i] = 1'b1;
        end else begin : g_casc
            assign up[i] = wrap[i-1];
        end

        // Channel 0 always has up=1, so MODE[0] cannot gate it.
        assign adv[i]    = EN & (~MODE[i] | up[i]);
        assign at_top[i] = (cnt == dsh);
        // SYNC/prime overrides any wrap on the same edge.
        assign wrap[i]   = adv[i] & ~load & at_top[i];

        always_comb begin
            cnt_nxt = cnt;
            dsh_nxt = dsh;
            ce_nxt  = 1'b0;
            written = 1'b0;
            if (load) begin
                written = 1'b1;
                dsh_nxt = div_i;
                // Out-of-range phase falls back to 0 so cnt never exceeds dsh.
                cnt_nxt = (ph_i <= div_i) ? ph_i : '0;
            end else if (wrap[i]) begin
                written = 1'b1;
                cnt_nxt = '0;
                dsh_nxt = div_i;
                ce_nxt  = 1'b1;
            end else if (adv[i]) begin
                written = 1'b1;
                cnt_nxt = cnt + ONE_CW;
            end
            // Divided clock is high while the new count is in the lower half.
            half   = ({1'b0, dsh_nxt} + ONE_W) >> 1;
            co_nxt = written ? ({1'b0, cnt_nxt} < half) : co_q;
        end

        always_ff @(posedge CLK_24M or negedge nRESET) begin
            if (!nRESET) begin
                cnt  <= '0;
                dsh  <= '0;
                ce_q <= 1'b0;
                co_q <= 1'b0;
            end else begin
                cnt  <= cnt_nxt;
                dsh  <= dsh_nxt;
                ce_q <= ce_nxt;
                co_q <= co_nxt;
            end
        end

        assign CE[i]      = ce_q;
        assign CLK_OUT[i] = co_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_clk_div_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clk_div_gen
//  Purpose  : Directed self-checking bench for clk_div_gen (NCH=4, CW=4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_clk_div_gen;

    logic        clk;
    logic        nRESET;
    logic        EN;
    logic        SYNC;
    logic [15:0] DIV;
    logic [15:0] PHASE;
    logic [3:0]  MODE;
    logic [3:0]  CE;
    logic [3:0]  CLK_OUT;
    logic        TC;

    int tests = 0;
    int fails = 0;

    clk_div_gen #(.NCH(4), .CW(4)) dut (
        .CLK_24M (clk),
        .nRESET  (nRESET),
        .EN      (EN),
        .SYNC    (SYNC),
        .DIV     (DIV),
        .PHASE   (PHASE),
        .MODE    (MODE),
        .CE      (CE),
        .CLK_OUT (CLK_OUT),
        .TC      (TC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One rising edge, then return on the falling edge for drive/sample.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        nRESET = 1'b0;
        #1;
        check("rst_ce",  {28'd0, CE},      32'd0);
        check("rst_clk", {28'd0, CLK_OUT}, 32'd0);
        check("rst_tc",  {31'd0, TC},      32'd0);
        step();
        step();
        check("rst_hold_ce",  {28'd0, CE},      32'd0);
        check("rst_hold_clk", {28'd0, CLK_OUT}, 32'd0);
        check("rst_hold_tc",  {31'd0, TC},      32'd0);
        nRESET = 1'b1;
    endtask

    initial begin
        logic [3:0] ece;
        logic [3:0] eclk;
        int         nv [4];

        nRESET = 1'b0;
        EN     = 1'b1;
        SYNC   = 1'b0;
        DIV    = 16'h7310;
        PHASE  = 16'h0000;
        MODE   = 4'b0000;
        @(negedge clk);

        // ---- Ratios 1/2/4/8, independent channels
        nv = '{1, 2, 4, 8};
        do_reset();
        step();  // prime edge
        check("t1_prime_ce",  {28'd0, CE},      32'h0);
        check("t1_prime_clk", {28'd0, CLK_OUT}, 32'he);
        check("t1_prime_tc",  {31'd0, TC},      32'h1);
        for (int k = 1; k <= 16; k++) begin
            step();
            for (int i = 0; i < 4; i++) begin
                ece[i]  = ((k % nv[i]) == 0);
                eclk[i] = ((k % nv[i]) < (nv[i] / 2));
            end
            check("t1_ce",  {28'd0, CE},      {28'd0, ece});
            check("t1_clk", {28'd0, CLK_OUT}, {28'd0, eclk});
        end

        // ---- Divide by 3 on channel 0
        DIV = 16'h0002;
        do_reset();
        for (int k = 0; k <= 8; k++) begin
            step();
            check("t2_clk0", {31'd0, CLK_OUT[0]}, {31'd0, (k % 3) == 0});
            check("t2_ce0",  {31'd0, CE[0]},      {31'd0, (k > 0) && ((k % 3) == 0)});
            check("t2_tc",   {31'd0, TC},         {31'd0, (k % 3) == 2});
        end

        // ---- Cascade chain of divide-by-2 stages
        DIV  = 16'h1111;
        MODE = 4'b1110;
        do_reset();
        for (int k = 0; k <= 32; k++) begin
            step();
            for (int i = 0; i < 4; i++) begin
                ece[i]  = (k > 0) && ((k % (2 << i)) == 0);
                eclk[i] = (((k >> i) & 1) == 0);
            end
            check("t3_ce",  {28'd0, CE},      {28'd0, ece});
            check("t3_clk", {28'd0, CLK_OUT}, {28'd0, eclk});
        end

        // ---- Ratio change mid-period takes effect at wrap
        MODE = 4'b0000;
        DIV  = 16'h0003;
        do_reset();
        step();  // prime, cnt0=0
        step();  // cnt0=1
        DIV = 16'h0001;
        for (int k = 2; k <= 8; k++) begin
            step();
            check("t4_ce0",  {31'd0, CE[0]},      {31'd0, (k == 4) || (k == 6) || (k == 8)});
            check("t4_clk0", {31'd0, CLK_OUT[0]}, {31'd0, (k >= 4) && ((k % 2) == 0)});
        end
        step();  // cnt0=1 == dsh0
        check("t5_tc_pre", {31'd0, TC}, 32'h1);

        // ---- SYNC with phase load
        DIV   = 16'h0030;
        PHASE = 16'h0020;
        SYNC  = 1'b1;
        #1;
        check("t5_tc_sync_mask", {31'd0, TC}, 32'h0);
        step();
        SYNC = 1'b0;
        check("t5_sync_ce",  {28'd0, CE},      32'h0);
        check("t5_sync_clk", {28'd0, CLK_OUT}, 32'h0);
        step();
        check("t5_p1_ce", {28'd0, CE}, 32'hd);
        step();
        check("t5_p2_ce",  {28'd0, CE},      32'hf);
        check("t5_p2_clk", {28'd0, CLK_OUT}, 32'h2);
        PHASE = 16'h0050;  // out of range for DIV_1=3
        SYNC  = 1'b1;
        step();
        SYNC = 1'b0;
        check("t5_oor_ce",  {28'd0, CE},      32'h0);
        check("t5_oor_clk", {28'd0, CLK_OUT}, 32'h2);
        for (int k = 1; k <= 4; k++) begin
            step();
            check("t5_oor_run_ce",  {28'd0, CE},      (k == 4) ? 32'hf : 32'hd);
            check("t5_oor_run_clk", {28'd0, CLK_OUT}, (k == 2 || k == 3) ? 32'h0 : 32'h2);
        end

        // ---- EN hold, then reset pulse mid-count
        DIV   = 16'h0007;
        PHASE = 16'h0000;
        SYNC  = 1'b1;
        step();
        SYNC = 1'b0;
        step();
        step();
        step();  // cnt0=3
        check("t6_run_ce",  {28'd0, CE},      32'he);
        check("t6_run_clk", {28'd0, CLK_OUT}, 32'h1);
        EN   = 1'b0;
        SYNC = 1'b1;  // must be ignored while disabled
        for (int k = 0; k < 5; k++) begin
            step();
            check("t6_hold_ce",  {28'd0, CE},      32'h0);
            check("t6_hold_clk", {28'd0, CLK_OUT}, 32'h1);
            check("t6_hold_tc",  {31'd0, TC},      32'h0);
        end
        SYNC = 1'b0;
        EN   = 1'b1;
        step();  // cnt0=4
        check("t6_res_ce",  {28'd0, CE},      32'he);
        check("t6_res_clk", {28'd0, CLK_OUT}, 32'h0);
        step();
        step();
        step();  // cnt0=7
        check("t6_res_tc", {31'd0, TC}, 32'h1);
        step();  // wrap
        check("t6_wrap_ce",  {28'd0, CE},      32'hf);
        check("t6_wrap_clk", {28'd0, CLK_OUT}, 32'h1);
        do_reset();
        step();  // prime edge, not an advance
        check("t6_prime_ce",  {28'd0, CE},      32'h0);
        check("t6_prime_clk", {28'd0, CLK_OUT}, 32'h1);
        step();
        check("t6_after_ce",  {28'd0, CE},      32'he);
        check("t6_after_clk", {28'd0, CLK_OUT}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clk_div_gen.md
CLK_DIV_GEN -- requirements
Module: clk_div_gen

Interface
REQ-001 Parameter NCH, default 4, number of divider channels (1..8).
REQ-002 Parameter CW, default 4, counter width per channel (2..8); divide ratio range 1..2^CW.
REQ-003 CLK_24M  in  1  sole clock, all state on rising edge.
REQ-004 nRESET  in  1  reset, asynchronous, active-low.
REQ-005 EN  in  1  global count enable.
REQ-006 SYNC  in  1  realign pulse; reloads all channels.
REQ-007 DIV  in  NCH*CW  per-channel ratio minus one (channel i at bits [i*CW +: CW]); N_i = DIV_i+1.
REQ-008 PHASE  in  NCH*CW  per-channel counter load value used on SYNC/prime.
REQ-009 MODE  in  NCH  per-channel cascade select; bit 0 ignored.
REQ-010 CE  out  NCH  registered one-cycle enable pulse per channel wrap.
REQ-011 CLK_OUT  out  NCH  registered divided clock per channel.
REQ-012 TC  out  1  combinational terminal count of channel 0.

Function
REQ-013 Each channel SHALL hold a CW-bit counter cnt_i and a CW-bit shadow ratio dsh_i; DIV changes SHALL take effect only at wrap, SYNC or prime.
REQ-014 A 1-bit prime flag SHALL be cleared by reset; the first edge with EN=1 SHALL set it and act as a SYNC.
REQ-015 Advance condition adv_i: channel 0 or MODE_i=0 -> adv_i = EN; MODE_i=1 -> adv_i = EN and channel i-1 wraps on the same edge.
REQ-016 SYNC/prime edge (EN=1): every channel loads dsh_i <= DIV_i, cnt_i <= PHASE_i if PHASE_i <= DIV_i else 0; CE_i <= 0; no wrap occurs; SYNC overrides wrap/advance.
REQ-017 Advance edge, cnt_i == dsh_i: wrap, cnt_i <= 0, dsh_i <= DIV_i, CE_i <= 1.
REQ-018 Advance edge, cnt_i != dsh_i: cnt_i <= cnt_i+1, CE_i <= 0.
REQ-019 Any edge with adv_i=0 and no SYNC/prime: cnt_i, dsh_i hold; CE_i <= 0.
REQ-020 CLK_OUT_i SHALL be loaded on every edge where cnt_i or dsh_i is written, with 1 iff new cnt_i < floor((new dsh_i+1)/2), else hold.
REQ-021 N=1: channel wraps on every advance edge, CE_i stays 1 while advancing, CLK_OUT_i stays 0.
REQ-022 Odd N: CLK_OUT_i high floor(N/2) of N counts (N=3 -> high 1 of 3).
REQ-023 TC = EN and prime and cnt_0 == dsh_0 and not SYNC.
REQ-024 EN=0: all state holds, CE all 0 after the next edge, TC=0; SYNC ignored while EN=0.
REQ-025 Cascaded channel sees channel i-1 wrap in the same edge (no extra latency per stage); chain of k N=2 channels divides by 2^k.
REQ-026 Counters SHALL never exceed dsh_i; no out-of-range state reachable.

Reset
REQ-027 nRESET low SHALL immediately force cnt_i=0, dsh_i=0, prime=0, CE=0, CLK_OUT=0; TC=0 consequently.
REQ-028 Reset assertion mid-count SHALL abandon the count; after release, first EN=1 edge primes per REQ-014.
REQ-029 Reset release SHALL be treated as asynchronous assert only; no edge within reset advances any state.

Verification
REQ-030 DIV={0,1,3,7} (ch0..3), MODE=0, PHASE=0, EN=1 after reset -> prime edge, then CLK_OUT periods 1(held 0)/2/4/8 cycles, CE_3 every 8 cycles, CE_0 constant 1.
REQ-031 DIV_0=2, EN=1 -> CLK_OUT_0 pattern 1,0,0 repeating; CE_0 high 1 of 3 cycles; TC high the cycle before each CE_0.
REQ-032 DIV={1,1,1,1}, MODE=4'b1110 -> CE_1 every 4, CE_2 every 8, CE_3 every 16 cycles; CLK_OUT_3 high 8 cycles of 16 counts of ch2 wraps.
REQ-033 Ch0 DIV=3 counting, change DIV to 1 at cnt_0=1 -> current period completes at 4 cycles, subsequent periods 2 cycles.
REQ-034 SYNC with PHASE_1=2, DIV_1=3 -> next cycle cnt_1=2, CE_1=0, wrap after 2 more edges; PHASE_1=5 -> cnt_1 loads 0.
REQ-035 EN dropped for 5 cycles mid-count then raised -> counts resume from held value, CE 0 during hold; nRESET pulse mid-count -> outputs 0 immediately, prime on next EN edge.
